// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: access size codes,
// FSM state and grant encodings, and per-size beat helpers.
package unified_mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        G_IF  = 1'b0,
        G_MEM = 1'b1
    } grant_e;

    // Size code 11 is handled as a word.
    function automatic logic [2:0] beats_for(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] last_beat(input logic [1:0] size);
        return 2'(beats_for(size) - 3'd1);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle around the arbiter: IF fetch port, MEM load/store port,
// pipeline stall and the byte-wide RAM port.
//   slave  : arbiter view (requests in, responses and RAM controls out)
//   master : pipeline + RAM view (requests out, responses in)
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;

    logic              mem_req;
    logic              mem_rw;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_misalign;

    logic              stall;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  mem_req, mem_rw, mem_size, mem_addr, mem_wdata,
        output mem_rdata, mem_done, mem_misalign,
        output stall,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output mem_req, mem_rw, mem_size, mem_addr, mem_wdata,
        input  mem_rdata, mem_done, mem_misalign,
        input  stall,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/unified_mem_arbiter_byte_lane_packer.sv
// Byte lane packer (combinational), big-endian: beat 0 carries the most
// significant byte of the N-byte item.
//   size            : access size code
//   wr_idx, wdata   : beat index and right-aligned store data -> wr_byte
//   rd_idx, rd_byte : beat index and byte read back from RAM
//   rd_cur          : result assembled so far -> rd_next
module unified_mem_arbiter_byte_lane_packer
    import unified_mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  wr_idx,
    input  logic [31:0] wdata,
    output logic [7:0]  wr_byte,
    input  logic [1:0]  rd_idx,
    input  logic [7:0]  rd_byte,
    input  logic [31:0] rd_cur,
    output logic [31:0] rd_next
);

    logic [1:0] wr_pos;
    logic [1:0] rd_pos;

    always_comb begin
        wr_pos  = last_beat(size) - wr_idx;
        rd_pos  = last_beat(size) - rd_idx;
        wr_byte = wdata[{wr_pos, 3'b000} +: 8];
        rd_next = rd_cur;
        rd_next[{rd_pos, 3'b000} +: 8] = rd_byte;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one byte-wide single-port RAM between the
// IF stage (word fetch) and the MEM stage (byte/half/word load/store).
// Each access is serialised into byte beats; stall is held while any
// accepted request is unfinished.
//   CLK  : system clock, rising edge
//   CLR  : asynchronous active-low reset
//   bus  : IF/MEM request ports, stall and RAM port (slave modport)
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter bit LAST_IF_RESET = 1'b0
) (
    input logic                  CLK,
    input logic                  CLR,
    unified_mem_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    grant_e            gnt_q, gnt_d, last_grant_q;
    logic              rw_q, mis_q;
    logic [1:0]        size_q, beat_q;
    logic [31:0]       wdata_q, res_q;
    logic [31:0]       if_rdata_q, mem_rdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;

    logic              req_any, sel_rw, sel_mis, beat_last;
    logic [1:0]        sel_size;
    logic [31:0]       sel_addr;

    logic [1:0]        pk_size, pk_wr_idx, pk_rd_idx;
    logic [31:0]       pk_wdata, pk_rd_next;
    logic [7:0]        pk_wr_byte;

    // Arbitration: on a tie the requester not served last wins.
    always_comb begin
        req_any = bus.if_req | bus.mem_req;
        gnt_d   = G_IF;
        if (bus.if_req && bus.mem_req)
            gnt_d = (last_grant_q == G_IF) ? G_MEM : G_IF;
        else if (bus.mem_req)
            gnt_d = G_MEM;
        sel_size  = (gnt_d == G_MEM) ? bus.mem_size : SZ_WORD;
        sel_addr  = (gnt_d == G_MEM) ? bus.mem_addr : bus.if_addr;
        sel_rw    = (gnt_d == G_MEM) & bus.mem_rw;
        sel_mis   = (gnt_d == G_MEM) & is_misaligned(bus.mem_size, bus.mem_addr[1:0]);
        beat_last = (beat_q == last_beat(size_q));
    end

    // Write side prepares the byte for the coming beat (beat 0 at grant).
    // Read side merges the byte of the previous beat; in DONE it merges
    // the final byte so the full result is visible with the done pulse.
    always_comb begin
        pk_size   = (state_q == IDLE) ? sel_size      : size_q;
        pk_wr_idx = (state_q == IDLE) ? 2'd0          : beat_q + 2'd1;
        pk_wdata  = (state_q == IDLE) ? bus.mem_wdata : wdata_q;
        pk_rd_idx = (state_q == DONE) ? last_beat(size_q) : beat_q - 2'd1;
    end

    unified_mem_arbiter_byte_lane_packer u_packer (
        .size    (pk_size),
        .wr_idx  (pk_wr_idx),
        .wdata   (pk_wdata),
        .wr_byte (pk_wr_byte),
        .rd_idx  (pk_rd_idx),
        .rd_byte (bus.ram_rdata),
        .rd_cur  (res_q),
        .rd_next (pk_rd_next)
    );

    // FSM: state register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_any) state_d = sel_mis ? DONE : XFER;
            XFER: if (beat_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.ram_en       = (state_q == XFER);
        bus.ram_we       = (state_q == XFER) & rw_q;
        bus.ram_addr     = ram_addr_q;
        bus.ram_wdata    = ram_wdata_q;
        bus.if_done      = (state_q == DONE) & (gnt_q == G_IF);
        bus.mem_done     = (state_q == DONE) & (gnt_q == G_MEM);
        bus.mem_misalign = (state_q == DONE) & mis_q;
        bus.if_rdata     = (bus.if_done & ~rw_q) ? pk_rd_next : if_rdata_q;
        bus.mem_rdata    = (bus.mem_done & ~rw_q & ~mis_q) ? pk_rd_next : mem_rdata_q;
        bus.stall        = (bus.if_req & ~bus.if_done) | (bus.mem_req & ~bus.mem_done);
    end

    // Request latches, beat counter, read assembly and result registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            gnt_q        <= G_IF;
            last_grant_q <= grant_e'(LAST_IF_RESET);
            rw_q         <= 1'b0;
            mis_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            beat_q       <= 2'd0;
            wdata_q      <= '0;
            res_q        <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        gnt_q   <= gnt_d;
                        rw_q    <= sel_rw;
                        mis_q   <= sel_mis;
                        size_q  <= sel_size;
                        wdata_q <= bus.mem_wdata;
                        beat_q  <= 2'd0;
                        res_q   <= '0;
                        // RAM-facing registers only move when a beat follows
                        if (!sel_mis) begin
                            ram_addr_q <= sel_addr[ADDR_W-1:0];
                            if (sel_rw) ram_wdata_q <= pk_wr_byte;
                        end
                    end
                end
                XFER: begin
                    if (!rw_q && beat_q != 2'd0) res_q <= pk_rd_next;
                    if (!beat_last) begin
                        beat_q     <= beat_q + 2'd1;
                        ram_addr_q <= ram_addr_q + 1'b1;
                        if (rw_q) ram_wdata_q <= pk_wr_byte;
                    end
                end
                DONE: begin
                    last_grant_q <= gnt_q;
                    if (!rw_q && !mis_q) begin
                        if (gnt_q == G_IF) if_rdata_q  <= pk_rd_next;
                        else               mem_rdata_q <= pk_rd_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    always #5 CLK = ~CLK;

    unified_mem_arbiter_if #(.ADDR_W(8)) bus();

    unified_mem_arbiter #(.ADDR_W(8), .LAST_IF_RESET(1'b0)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    logic [7:0] ram [256];

    always @(posedge CLK) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= ram[bus.ram_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_if_rdata"},  bus.if_rdata, 32'h0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata, 32'h0);
        chk({tag, "_dones"},     {29'b0, bus.if_done, bus.mem_done, bus.mem_misalign}, 32'h0);
        chk({tag, "_stall"},     {31'b0, bus.stall}, 32'h0);
        chk({tag, "_ram_ctl"},   {30'b0, bus.ram_en, bus.ram_we}, 32'h0);
        chk({tag, "_ram_bus"},   {16'b0, bus.ram_addr, bus.ram_wdata}, 32'h0);
    endtask

    // One request from a single requester; checks every beat, the latency,
    // misalign flag, returned data and the single-cycle done pulse.
    task automatic xact(input bit is_if, input bit rw, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int n_beats, input int exp_lat, input bit exp_mis,
                        input logic [31:0] exp_rdata, input string tag);
        int          cyc   = 0;
        int          beats = 0;
        bit          done  = 1'b0;
        logic [31:0] wd    = wdata;
        logic [7:0]  a0    = addr[7:0];
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_rw    = rw;
            bus.mem_size  = size;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
        end
        #1;
        chk({tag, "_stall_grant"}, {31'b0, bus.stall}, 32'h1);
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (bus.ram_en) begin
                chk({tag, "_beat_addr"}, {24'b0, bus.ram_addr}, {24'b0, 8'(a0 + 8'(beats))});
                chk({tag, "_beat_we"}, {31'b0, bus.ram_we}, {31'b0, rw});
                if (rw)
                    chk({tag, "_beat_wdata"}, {24'b0, bus.ram_wdata},
                        {24'b0, wd[8*(n_beats-1-beats) +: 8]});
                beats++;
            end
            done = is_if ? bus.if_done : bus.mem_done;
            if (!done) chk({tag, "_stall_busy"}, {31'b0, bus.stall}, 32'h1);
        end
        chk({tag, "_done_seen"}, {31'b0, done}, 32'h1);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_beats"}, beats, n_beats);
        chk({tag, "_misalign"}, {31'b0, bus.mem_misalign}, {31'b0, exp_mis});
        chk({tag, "_rdata"}, is_if ? bus.if_rdata : bus.mem_rdata, exp_rdata);
        chk({tag, "_stall_done"}, {31'b0, bus.stall}, 32'h0);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        tick();
        chk({tag, "_pulse_end"}, {30'b0, bus.if_done, bus.mem_done}, 32'h0);
        chk({tag, "_rdata_hold"}, is_if ? bus.if_rdata : bus.mem_rdata, exp_rdata);
    endtask

    task automatic wait_done(input bit want_if, input string tag, output int cyc);
        bit got   = 1'b0;
        bit other = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            got = want_if ? bus.if_done : bus.mem_done;
            if (want_if ? bus.mem_done : bus.if_done) other = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'b0, got}, 32'h1);
        chk({tag, "_other_done"}, {31'b0, other}, 32'h0);
    endtask

    initial begin
        int cyc;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_size  = SZ_BYTE;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.ram_rdata = '0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0]   = 8'hE3; ram[1]   = 8'hA0; ram[2]   = 8'h10; ram[3]   = 8'h05;
        ram[252] = 8'hDE; ram[253] = 8'hAD; ram[254] = 8'hBE; ram[255] = 8'hEF;

        CLR = 1'b0;
        tick(); tick();
        chk_outputs_zero("reset");
        CLR = 1'b1;
        tick();

        // Instruction fetch from 0
        xact(1'b1, 1'b0, SZ_WORD, 32'h0, 32'h0, 4, 5, 1'b0, 32'hE3A01005, "t1_fetch");

        // Word store then byte load
        xact(1'b0, 1'b1, SZ_WORD, 32'h14, 32'h11223344, 4, 5, 1'b0, 32'h0, "t2_wr");
        chk("t2_ram14", {ram[8'h14], ram[8'h15], ram[8'h16], ram[8'h17]}, 32'h11223344);
        xact(1'b0, 1'b0, SZ_BYTE, 32'h16, 32'h0, 1, 2, 1'b0, 32'h00000033, "t2_rd");

        // Halfword store (upper wdata ignored) and load back
        xact(1'b0, 1'b1, SZ_HALF, 32'h30, 32'hCAFEBEEF, 2, 3, 1'b0, 32'h00000033, "hw_wr");
        chk("hw_ram30", {16'b0, ram[8'h30], ram[8'h31]}, 32'h0000BEEF);
        chk("hw_ram32", {24'b0, ram[8'h32]}, 32'h0);
        xact(1'b0, 1'b0, SZ_HALF, 32'h30, 32'h0, 2, 3, 1'b0, 32'h0000BEEF, "hw_rd");

        // Simultaneous requests after reset: MEM, IF, then MEM again
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
        tick();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0;
        bus.mem_req  = 1'b1;
        bus.mem_rw   = 1'b0;
        bus.mem_size = SZ_WORD;
        bus.mem_addr = 32'h14;
        wait_done(1'b0, "t3_mem1", cyc);
        chk("t3_mem1_lat", cyc, 5);
        chk("t3_mem1_rdata", bus.mem_rdata, 32'h11223344);
        chk("t3_mem1_stall", {31'b0, bus.stall}, 32'h1);
        bus.mem_req = 1'b0;
        wait_done(1'b1, "t3_if1", cyc);
        chk("t3_if1_lat", cyc, 6);
        chk("t3_if1_rdata", bus.if_rdata, 32'hE3A01005);
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'hFC;
        wait_done(1'b0, "t3_mem2", cyc);
        chk("t3_mem2_lat", cyc, 6);
        chk("t3_mem2_rdata", bus.mem_rdata, 32'hDEADBEEF);
        bus.mem_req = 1'b0;
        wait_done(1'b1, "t3_if2", cyc);
        chk("t3_if2_lat", cyc, 6);
        bus.if_req = 1'b0;
        tick();

        // Misaligned halfword: no beats, immediate done with misalign
        xact(1'b0, 1'b0, SZ_HALF, 32'h21, 32'h0, 0, 1, 1'b1, 32'hDEADBEEF, "t4_mis");
        xact(1'b0, 1'b0, 2'b11, 32'h22, 32'h0, 0, 1, 1'b1, 32'hDEADBEEF, "t4_mis11");

        // Top-of-RAM word, with and without upper address bits
        xact(1'b0, 1'b0, SZ_BYTE, 32'h16, 32'h0, 1, 2, 1'b0, 32'h00000033, "t5_sep");
        xact(1'b0, 1'b0, SZ_WORD, 32'hFC, 32'h0, 4, 5, 1'b0, 32'hDEADBEEF, "t5_lo");
        xact(1'b0, 1'b0, SZ_BYTE, 32'h16, 32'h0, 1, 2, 1'b0, 32'h00000033, "t5_sep2");
        xact(1'b0, 1'b0, SZ_WORD, 32'h100000FC, 32'h0, 4, 5, 1'b0, 32'hDEADBEEF, "t5_hi");

        // Reset during a word store, after its second beat has been written
        bus.mem_req   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_size  = SZ_WORD;
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'hAABBCCDD;
        tick(); tick(); tick();
        CLR         = 1'b0;
        bus.mem_req = 1'b0;
        #1;
        chk_outputs_zero("t6_rst");
        tick(); tick();
        chk("t6_ram40", {ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]}, 32'hAABB0000);
        chk("t6_no_done", {30'b0, bus.mem_done, bus.if_done}, 32'h0);
        CLR = 1'b1;
        tick();
        xact(1'b0, 1'b0, SZ_BYTE, 32'h41, 32'h0, 1, 2, 1'b0, 32'h000000BB, "t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
